// File: rtl/framed_stack_pkg.sv
// framed_stack_pkg: operation and status encodings shared by the framed
// operand stack, its frame-base LIFO and anything driving them.
package framed_stack_pkg;

    typedef enum logic [2:0] {
        OP_NONE        = 3'd0,
        OP_PUSH        = 3'd1,
        OP_POP         = 3'd2,
        OP_REPLACE     = 3'd3,
        OP_PICK        = 3'd4,
        OP_CALL        = 3'd5,
        OP_RETURN      = 3'd6,
        OP_FRAME_RESET = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_NONE            = 3'd0,
        ST_EMPTY           = 3'd1,
        ST_FULL            = 3'd2,
        ST_OVERFLOW        = 3'd3,
        ST_UNDERFLOW       = 3'd4,
        ST_FRAME_OVERFLOW  = 3'd5,
        ST_FRAME_UNDERFLOW = 3'd6
    } status_e;

endpackage

// File: rtl/base_lifo.sv
// base_lifo: small LIFO of saved frame bases (DEPTH+1 bits each,
// 2**FRAMES entries). dout is the most recently pushed base, 0 when empty.
// Pushing when full or popping when empty is ignored.
module base_lifo
    import framed_stack_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FRAMES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [DEPTH:0]  din,
    output logic [DEPTH:0]  dout,
    output logic [FRAMES:0] level
);

    localparam int              SLOTS   = 1 << FRAMES;
    localparam logic [FRAMES:0] LVL_ONE = (FRAMES + 1)'(1);
    localparam logic [FRAMES:0] LVL_MAX = {1'b1, {FRAMES{1'b0}}};

    logic [DEPTH:0]  mem_q [SLOTS];
    logic [FRAMES:0] level_q, level_d;
    logic            push_ok, pop_ok;

    assign push_ok = push && (level_q != LVL_MAX);
    assign pop_ok  = pop  && (level_q != '0);

    // Next occupancy count; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok)
            level_d = level_q + LVL_ONE;
        else if (pop_ok && !push_ok)
            level_d = level_q - LVL_ONE;
    end

    // Occupancy register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            level_q <= '0;
        else
            level_q <= level_d;
    end

    // Base storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !reset)
            mem_q[level_q[FRAMES-1:0]] <= din;
    end

    assign dout  = (level_q == '0) ? '0 : mem_q[FRAMES'(level_q - LVL_ONE)];
    assign level = level_q;

endmodule

// File: rtl/framed_stack.sv
// framed_stack: operand stack with an internal frame-base LIFO. CALL saves
// the underflow limit and starts a new frame at the current index; RETURN
// restores it. PICK reads at a depth offset inside the current frame.
// Optional build macro RETURN_VALUE_EN: RETURN from a non-empty frame keeps
// the old top of stack as a single return value on the caller's frame.
module framed_stack
    import framed_stack_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  data,
    input  logic [DEPTH-1:0]  offset,
    output logic [DEPTH:0]    index,
    output logic [DEPTH:0]    frame_base,
    output logic [FRAMES:0]   frame_level,
    output logic [WIDTH-1:0]  tos,
    output logic [WIDTH-1:0]  pick_data,
    output logic [2:0]        status
);

    localparam int              MAX     = 1 << DEPTH;
    localparam logic [DEPTH:0]  MAX_IDX = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0]  IDX_ONE = (DEPTH + 1)'(1);
    localparam logic [FRAMES:0] MAX_LVL = {1'b1, {FRAMES{1'b0}}};

    op_e              op_c;
    logic [WIDTH-1:0] mem_q [MAX];
    logic [DEPTH:0]   index_q, index_d;
    logic [DEPTH:0]   base_q, base_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] pick_q, pick_d;
    status_e          status_q, status_d;
    logic             has_err;
    status_e          err_code;
    logic [DEPTH:0]   n_vals;
    logic [DEPTH:0]   pick_cnt;
    logic             mem_we;
    logic [DEPTH-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             lifo_push, lifo_pop;
    logic [DEPTH:0]   lifo_dout;
    logic [FRAMES:0]  lifo_level;

    assign op_c     = op_e'(op);
    assign n_vals   = index_q - base_q;
    // A stack trimmed to pick_cnt entries has mem[index-1-offset] on top.
    assign pick_cnt = index_q - {1'b0, offset};

    // Top value of a stack holding cnt entries (0 when cnt is 0).
    function automatic logic [WIDTH-1:0] value_below(input logic [DEPTH:0] cnt);
        return (cnt == '0) ? '0 : mem_q[DEPTH'(cnt - IDX_ONE)];
    endfunction

    base_lifo #(
        .DEPTH  (DEPTH),
        .FRAMES (FRAMES)
    ) u_base_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .din   (base_q),
        .dout  (lifo_dout),
        .level (lifo_level)
    );

    // Decode the op: error checks first, then next state and memory write.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        index_d   = index_q;
        base_d    = base_q;
        tos_d     = tos_q;
        pick_d    = pick_q;
        has_err   = 1'b0;
        err_code  = ST_NONE;
        mem_we    = 1'b0;
        mem_waddr = index_q[DEPTH-1:0];
        mem_wdata = data;
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;

        case (op_c)
            OP_PUSH: begin
                if (index_q == MAX_IDX) begin
                    has_err  = 1'b1;
                    err_code = ST_OVERFLOW;
                end else begin
                    mem_we  = 1'b1;
                    index_d = index_q + IDX_ONE;
                    tos_d   = data;
                end
            end
            OP_POP: begin
                if (n_vals == '0) begin
                    has_err  = 1'b1;
                    err_code = ST_UNDERFLOW;
                end else begin
                    index_d = index_q - IDX_ONE;
                    tos_d   = value_below(index_q - IDX_ONE);
                end
            end
            OP_REPLACE: begin
                if (n_vals == '0) begin
                    has_err  = 1'b1;
                    err_code = ST_UNDERFLOW;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = DEPTH'(index_q - IDX_ONE);
                    tos_d     = data;
                end
            end
            OP_PICK: begin
                if ({1'b0, offset} >= n_vals) begin
                    has_err  = 1'b1;
                    err_code = ST_UNDERFLOW;
                end else begin
                    pick_d = value_below(pick_cnt);
                end
            end
            OP_CALL: begin
                if (lifo_level == MAX_LVL) begin
                    has_err  = 1'b1;
                    err_code = ST_FRAME_OVERFLOW;
                end else begin
                    lifo_push = 1'b1;
                    base_d    = index_q;
                end
            end
            OP_RETURN: begin
                if (lifo_level == '0) begin
                    has_err  = 1'b1;
                    err_code = ST_FRAME_UNDERFLOW;
                end else begin
                    lifo_pop = 1'b1;
                    base_d   = lifo_dout;
`ifdef RETURN_VALUE_EN
                    if (n_vals != '0) begin
                        // Old TOS becomes the single value left at the callee base.
                        mem_we    = 1'b1;
                        mem_waddr = base_q[DEPTH-1:0];
                        mem_wdata = tos_q;
                        index_d   = base_q + IDX_ONE;
                        tos_d     = tos_q;
                    end else begin
                        index_d = base_q;
                        tos_d   = value_below(base_q);
                    end
`else
                    index_d = base_q;
                    tos_d   = value_below(base_q);
`endif
                end
            end
            OP_FRAME_RESET: begin
                index_d = base_q;
                tos_d   = value_below(base_q);
            end
            default: ;
        endcase

        if (has_err)
            status_d = err_code;
        else if (index_d == base_d)
            status_d = ST_EMPTY;
        else if (index_d == MAX_IDX)
            status_d = ST_FULL;
        else
            status_d = ST_NONE;
    end

    // Architectural registers, cleared asynchronously; reset beats any op.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge state, independent of statement order.
        if (reset) begin
            index_q  <= '0;
            base_q   <= '0;
            tos_q    <= '0;
            pick_q   <= '0;
            status_q <= ST_EMPTY;
        end else begin
            index_q  <= index_d;
            base_q   <= base_d;
            tos_q    <= tos_d;
            pick_q   <= pick_d;
            status_q <= status_d;
        end
    end

    // Value memory write port.
    always_ff @(posedge clk) begin
        // NOTE: the value memory is deliberately not reset; index bounds every
        // read, so stale contents are never observable.
        if (mem_we && !reset)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign index       = index_q;
    assign frame_base  = base_q;
    assign frame_level = lifo_level;
    assign tos         = tos_q;
    assign pick_data   = pick_q;
    assign status      = status_q;

endmodule

// File: tb/tb_framed_stack.sv
// tb_framed_stack: table-driven check of framed_stack (WIDTH=8, DEPTH=2,
// FRAMES=1) with a scoreboard queue, plus a hand-written reset-mid-op case.
module tb_framed_stack;
    import framed_stack_pkg::*;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 2;
    localparam int FRAMES = 1;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        op    = OP_NONE;
    logic [WIDTH-1:0]  data  = '0;
    logic [DEPTH-1:0]  offset = '0;
    logic [DEPTH:0]    index;
    logic [DEPTH:0]    frame_base;
    logic [FRAMES:0]   frame_level;
    logic [WIDTH-1:0]  tos;
    logic [WIDTH-1:0]  pick_data;
    logic [2:0]        status;

    typedef struct {
        bit          rst_first;
        logic [2:0]  op;
        logic [7:0]  data;
        logic [1:0]  offset;
        logic [2:0]  e_index;
        logic [7:0]  e_tos;
        logic [2:0]  e_status;
        logic [2:0]  e_base;
        logic [1:0]  e_level;
        logic [7:0]  e_pick;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    framed_stack #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .FRAMES (FRAMES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .data        (data),
        .offset      (offset),
        .index       (index),
        .frame_base  (frame_base),
        .frame_level (frame_level),
        .tos         (tos),
        .pick_data   (pick_data),
        .status      (status)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic [2:0] o, input logic [7:0] d, input logic [1:0] off,
                       input logic [2:0] ei, input logic [7:0] et, input logic [2:0] es,
                       input logic [2:0] eb, input logic [1:0] el, input logic [7:0] ep);
        vecs.push_back('{r, o, d, off, ei, et, es, eb, el, ep});
    endtask

    // Assert reset asynchronously and confirm all outputs clear while held.
    task automatic do_reset(input string tag);
        @(negedge clk);
        op    = OP_NONE;
        reset = 1'b1;
        #2;
        check({tag, ".rst.index"}, 32'(index), 0);
        check({tag, ".rst.base"},  32'(frame_base), 0);
        check({tag, ".rst.level"}, 32'(frame_level), 0);
        check({tag, ".rst.tos"},   32'(tos), 0);
        check({tag, ".rst.pick"},  32'(pick_data), 0);
        check({tag, ".rst.status"}, 32'(status), 32'(ST_EMPTY));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one op, queue its expectation, compare one cycle later.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        op     = v.op;
        data   = v.data;
        offset = v.offset;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check({tag, ".sb_pending"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ".index"},  32'(index),       32'(e.e_index));
            check({tag, ".tos"},    32'(tos),         32'(e.e_tos));
            check({tag, ".status"}, 32'(status),      32'(e.e_status));
            check({tag, ".base"},   32'(frame_base),  32'(e.e_base));
            check({tag, ".level"},  32'(frame_level), 32'(e.e_level));
            check({tag, ".pick"},   32'(pick_data),   32'(e.e_pick));
        end
        op = OP_NONE;
    endtask

    initial begin
        // rst op data off | idx tos status base lvl pick
        // Fill, overflow, replace, pop.
        add(1, OP_POP,     8'h00, 0, 0, 8'h00, ST_UNDERFLOW, 0, 0, 8'h00);
        add(0, OP_PUSH,    8'h11, 0, 1, 8'h11, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PUSH,    8'h22, 0, 2, 8'h22, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PUSH,    8'h33, 0, 3, 8'h33, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PUSH,    8'h44, 0, 4, 8'h44, ST_FULL,      0, 0, 8'h00);
        add(0, OP_PUSH,    8'h55, 0, 4, 8'h44, ST_OVERFLOW,  0, 0, 8'h00);
        add(0, OP_NONE,    8'h00, 0, 4, 8'h44, ST_FULL,      0, 0, 8'h00);
        add(0, OP_REPLACE, 8'h66, 0, 4, 8'h66, ST_FULL,      0, 0, 8'h00);
        add(0, OP_POP,     8'h00, 0, 3, 8'h33, ST_NONE,      0, 0, 8'h00);
        add(0, OP_POP,     8'h00, 0, 2, 8'h22, ST_NONE,      0, 0, 8'h00);
        // Frame protection, frame reset, return from an emptied frame.
        add(1, OP_PUSH,    8'h01, 0, 1, 8'h01, ST_NONE,      0, 0, 8'h00);
        add(0, OP_CALL,    8'h00, 0, 1, 8'h01, ST_EMPTY,     1, 1, 8'h00);
        add(0, OP_POP,     8'h00, 0, 1, 8'h01, ST_UNDERFLOW, 1, 1, 8'h00);
        add(0, OP_NONE,    8'h00, 0, 1, 8'h01, ST_EMPTY,     1, 1, 8'h00);
        add(0, OP_REPLACE, 8'h99, 0, 1, 8'h01, ST_UNDERFLOW, 1, 1, 8'h00);
        add(0, OP_PUSH,    8'h02, 0, 2, 8'h02, ST_NONE,      1, 1, 8'h00);
        add(0, OP_FRAME_RESET, 8'h00, 0, 1, 8'h01, ST_EMPTY, 1, 1, 8'h00);
        add(0, OP_RETURN,  8'h00, 0, 1, 8'h01, ST_NONE,      0, 0, 8'h00);
        // Frame LIFO overflow / underflow.
        add(1, OP_CALL,    8'h00, 0, 0, 8'h00, ST_EMPTY,           0, 1, 8'h00);
        add(0, OP_CALL,    8'h00, 0, 0, 8'h00, ST_EMPTY,           0, 2, 8'h00);
        add(0, OP_CALL,    8'h00, 0, 0, 8'h00, ST_FRAME_OVERFLOW,  0, 2, 8'h00);
        add(0, OP_RETURN,  8'h00, 0, 0, 8'h00, ST_EMPTY,           0, 1, 8'h00);
        add(0, OP_RETURN,  8'h00, 0, 0, 8'h00, ST_EMPTY,           0, 0, 8'h00);
        add(0, OP_RETURN,  8'h00, 0, 0, 8'h00, ST_FRAME_UNDERFLOW, 0, 0, 8'h00);
        add(0, OP_NONE,    8'h00, 0, 0, 8'h00, ST_EMPTY,           0, 0, 8'h00);
        // PICK at depth, bounds relative to the current frame.
        add(1, OP_PUSH,    8'hA0, 0, 1, 8'hA0, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PUSH,    8'hB0, 0, 2, 8'hB0, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PUSH,    8'hC0, 0, 3, 8'hC0, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PICK,    8'h00, 2, 3, 8'hC0, ST_NONE,      0, 0, 8'hA0);
        add(0, OP_PICK,    8'h00, 3, 3, 8'hC0, ST_UNDERFLOW, 0, 0, 8'hA0);
        add(0, OP_PICK,    8'h00, 0, 3, 8'hC0, ST_NONE,      0, 0, 8'hC0);
        add(0, OP_PICK,    8'h00, 1, 3, 8'hC0, ST_NONE,      0, 0, 8'hB0);
        add(0, OP_CALL,    8'h00, 0, 3, 8'hC0, ST_EMPTY,     3, 1, 8'hB0);
        add(0, OP_PICK,    8'h00, 0, 3, 8'hC0, ST_UNDERFLOW, 3, 1, 8'hB0);
        add(0, OP_PUSH,    8'hD0, 0, 4, 8'hD0, ST_FULL,      3, 1, 8'hB0);
        add(0, OP_PICK,    8'h00, 0, 4, 8'hD0, ST_FULL,      3, 1, 8'hD0);
        add(0, OP_PICK,    8'h00, 1, 4, 8'hD0, ST_UNDERFLOW, 3, 1, 8'hD0);
        // RETURN with values in the callee frame.
        add(1, OP_PUSH,    8'h07, 0, 1, 8'h07, ST_NONE,      0, 0, 8'h00);
        add(0, OP_CALL,    8'h00, 0, 1, 8'h07, ST_EMPTY,     1, 1, 8'h00);
        add(0, OP_PUSH,    8'h08, 0, 2, 8'h08, ST_NONE,      1, 1, 8'h00);
        add(0, OP_PUSH,    8'h09, 0, 3, 8'h09, ST_NONE,      1, 1, 8'h00);
`ifdef RETURN_VALUE_EN
        add(0, OP_RETURN,  8'h00, 0, 2, 8'h09, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PICK,    8'h00, 0, 2, 8'h09, ST_NONE,      0, 0, 8'h09);
        add(0, OP_POP,     8'h00, 0, 1, 8'h07, ST_NONE,      0, 0, 8'h09);
`else
        add(0, OP_RETURN,  8'h00, 0, 1, 8'h07, ST_NONE,      0, 0, 8'h00);
        add(0, OP_PICK,    8'h00, 0, 1, 8'h07, ST_NONE,      0, 0, 8'h07);
        add(0, OP_POP,     8'h00, 0, 0, 8'h00, ST_EMPTY,     0, 0, 8'h07);
`endif

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first)
                do_reset($sformatf("v%0d", i));
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted during a PUSH cycle wins over the op.
        do_reset("mid");
        apply('{0, OP_PUSH, 8'h12, 0, 1, 8'h12, ST_NONE,  0, 0, 8'h00}, "mid.push");
        apply('{0, OP_CALL, 8'h00, 0, 1, 8'h12, ST_EMPTY, 1, 1, 8'h00}, "mid.call");
        @(negedge clk);
        op   = OP_PUSH;
        data = 8'h5A;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid.index",  32'(index), 0);
        check("mid.tos",    32'(tos), 0);
        check("mid.status", 32'(status), 32'(ST_EMPTY));
        check("mid.base",   32'(frame_base), 0);
        check("mid.level",  32'(frame_level), 0);
        @(negedge clk);
        reset = 1'b0;
        op    = OP_NONE;
        apply('{0, OP_PUSH, 8'h3C, 0, 1, 8'h3C, ST_NONE, 0, 0, 8'h00}, "mid.after");

        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/framed_stack.md
Name: framed_stack

Overview:
- Parametrised successor to the single-limit operand stack for the wasm execution core.
- Adds an internal frame-base LIFO, so CALL/RETURN save and restore the underflow limit without an external limit input.
- Adds PICK (read at depth offset) and FRAME_RESET.
- Feeds the operand datapath and the call/return sequencer.

Parameters:
- WIDTH, 8: data word width.
- DEPTH, 4: value stack holds 2**DEPTH entries; index width DEPTH+1.
- FRAMES, 2: frame-base LIFO holds 2**FRAMES saved bases; level width FRAMES+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  3  operation code (package constants).
- data  in  WIDTH  push/replace operand.
- offset  in  DEPTH  PICK depth; 0 = TOS.
- index  out  DEPTH+1  number of stored values.
- frame_base  out  DEPTH+1  current underflow limit.
- frame_level  out  FRAMES+1  number of saved frames.
- tos  out  WIDTH  registered top of stack.
- pick_data  out  WIDTH  registered PICK result.
- status  out  3  registered result of last op.

Behaviour:
- Reset (async): index=0, frame_base=0, frame_level=0, tos=0, pick_data=0, status=EMPTY. Value memory is not cleared. Reset asserted mid-op wins; that op is lost.
- All ops take effect on the clk edge. tos, index and status are valid the following cycle (1-cycle latency). Ops are accepted every cycle.
- Let n = index - frame_base (values in the current frame); MAX = 2**DEPTH.
- NONE: state held. status is recomputed.
- PUSH:
  - if index==MAX: status=OVERFLOW, nothing changes.
  - else: mem[index]=data, index+1, tos=data.
- POP:
  - if n==0: UNDERFLOW, nothing changes.
  - else: index-1, tos=mem[index-2] (tos=0 if the new index is 0).
- REPLACE:
  - if n==0: UNDERFLOW, no change.
  - else: mem[index-1]=data, tos=data.
- PICK:
  - if offset>=n: UNDERFLOW, pick_data unchanged.
  - else: pick_data=mem[index-1-offset]. The stack is unchanged.
- CALL:
  - if frame_level==2**FRAMES: FRAME_OVERFLOW, no change.
  - else: push frame_base to the LIFO, frame_base=index, frame_level+1.
- RETURN:
  - if frame_level==0: FRAME_UNDERFLOW, no change.
  - else: index=frame_base, frame_base=popped base, frame_level-1, tos=mem[new index-1] (0 if empty).
- FRAME_RESET: index=frame_base, tos updated as for RETURN, frame_level unchanged.
- Non-error status priority after the update: EMPTY if index==frame_base, else FULL if index==MAX, else NONE.
- Errors (OVERFLOW, UNDERFLOW, FRAME_OVERFLOW, FRAME_UNDERFLOW) are reported for one cycle only.
- Arithmetic is unsigned. index never wraps; error checks precede every update.

Optional Feature:
- Macro RETURN_VALUE_EN.
- Defined:
  - RETURN with n>=1 copies the old TOS to mem[base] and sets index=base+1, tos=old TOS.
  - RETURN with n==0 behaves as undefined-macro.
  - The copy is done in the same cycle, with no extra latency.
- Undefined: RETURN discards all frame values.

Decomposition:
- Shared include/package (extend stack.vh):
  - op codes: NONE=0, PUSH=1, POP=2, REPLACE=3, PICK=4, CALL=5, RETURN=6, FRAME_RESET=7.
  - status codes: NONE=0, EMPTY=1, FULL=2, OVERFLOW=3, UNDERFLOW=4, FRAME_OVERFLOW=5, FRAME_UNDERFLOW=6.
- One sub-module: base_lifo.
  - Parametrised LIFO of DEPTH+1-bit bases, 2**FRAMES entries.
  - Ports: push, pop, din, dout, level.
  - Owns the frame LIFO; framed_stack owns the value memory and status.

Test Plan (WIDTH=8, DEPTH=2, FRAMES=1):
- Reset, then POP -> status UNDERFLOW, index 0. Then PUSH 0x11, 0x22, 0x33, 0x44 -> status FULL, tos 0x44. Then PUSH 0x55 -> OVERFLOW, tos 0x44.
- From empty: PUSH 0x01, CALL, then POP -> UNDERFLOW (protected). Then NONE -> EMPTY, frame_base 1, frame_level 1.
- CALL, CALL, CALL -> third gives FRAME_OVERFLOW, frame_level 2. Then RETURN x3 -> third gives FRAME_UNDERFLOW, frame_base 0.
- PUSH 0xA0, 0xB0, 0xC0; PICK offset 2 -> pick_data 0xA0, index 3. Then PICK offset 3 -> UNDERFLOW, pick_data still 0xA0.
- PUSH 0x07, CALL, PUSH 0x08, 0x09, RETURN:
  - with RETURN_VALUE_EN: index 2, tos 0x09.
  - without: index 1, tos 0x07.
  - both: status NONE.
- Assert reset during a PUSH cycle -> index 0, tos 0, status EMPTY that cycle. Then PUSH 0x3C -> tos 0x3C, NONE.
